// File: rtl/tl_pkg.sv
// Shared TL-UH opcode encodings and message helpers used by the host arbiter.
package tl_pkg;

  localparam int TlSizeW = 4;
  localparam int TlCntW  = 16;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    ArithmeticData = 3'h2,
    LogicalData    = 3'h3,
    Get            = 3'h4,
    Intent         = 3'h5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1,
    HintAck       = 3'h2
  } tl_d_op_e;

  // Only Put messages wider than one beat span several beats; everything else is a single beat.
  function automatic logic [TlCntW-1:0] tl_beats(input tl_a_op_e opcode,
                                                 input logic [TlSizeW-1:0] size,
                                                 input int unsigned beat_bytes_log2);
    logic [TlCntW-1:0] beats;
    beats = TlCntW'(1);
    if ((opcode == PutFullData || opcode == PutPartialData) && 32'(size) > beat_bytes_log2) begin
      beats = TlCntW'(1) << (32'(size) - beat_bytes_log2);
    end
    return beats;
  endfunction

endpackage

// File: rtl/tl_host_arbiter_if.sv
// Host-side and device-side TL-UH channels of the arbiter; device source carries the host index.
interface tl_host_arbiter_if #(
  parameter int NumHosts    = 2,
  parameter int SourceWidth = 1,
  parameter int SinkWidth   = 1,
  parameter int AddrWidth   = 56,
  parameter int DataWidth   = 64
);
  import tl_pkg::*;

  localparam int IdxWidth       = $clog2(NumHosts);
  localparam int DevSourceWidth = SourceWidth + IdxWidth;

  typedef struct packed {
    tl_a_op_e                 opcode;
    logic [2:0]               param;
    logic [TlSizeW-1:0]       size;
    logic [SourceWidth-1:0]   source;
    logic [AddrWidth-1:0]     address;
    logic [DataWidth/8-1:0]   mask;
    logic [DataWidth-1:0]     data;
  } host_a_t;

  typedef struct packed {
    tl_a_op_e                 opcode;
    logic [2:0]               param;
    logic [TlSizeW-1:0]       size;
    logic [DevSourceWidth-1:0] source;
    logic [AddrWidth-1:0]     address;
    logic [DataWidth/8-1:0]   mask;
    logic [DataWidth-1:0]     data;
  } dev_a_t;

  typedef struct packed {
    tl_d_op_e                 opcode;
    logic [2:0]               param;
    logic [TlSizeW-1:0]       size;
    logic [SourceWidth-1:0]   source;
    logic [SinkWidth-1:0]     sink;
    logic [DataWidth-1:0]     data;
    logic                     error;
  } host_d_t;

  typedef struct packed {
    tl_d_op_e                 opcode;
    logic [2:0]               param;
    logic [TlSizeW-1:0]       size;
    logic [DevSourceWidth-1:0] source;
    logic [SinkWidth-1:0]     sink;
    logic [DataWidth-1:0]     data;
    logic                     error;
  } dev_d_t;

  logic [NumHosts-1:0] host_a_valid;
  logic [NumHosts-1:0] host_a_ready;
  host_a_t             host_a [NumHosts];
  logic [NumHosts-1:0] host_d_valid;
  logic [NumHosts-1:0] host_d_ready;
  host_d_t             host_d [NumHosts];
  logic                device_a_valid;
  logic                device_a_ready;
  dev_a_t              device_a;
  logic                device_d_valid;
  logic                device_d_ready;
  dev_d_t              device_d;

  modport slave (
    input  host_a_valid, host_a, host_d_ready, device_a_ready, device_d_valid, device_d,
    output host_a_ready, host_d_valid, host_d, device_a_valid, device_a, device_d_ready
  );

  modport master (
    output host_a_valid, host_a, host_d_ready, device_a_ready, device_d_valid, device_d,
    input  host_a_ready, host_d_valid, host_d, device_a_valid, device_a, device_d_ready
  );

endinterface

// File: rtl/tl_host_arbiter_rr.sv
// Host picker: round-robin when TL_ARB_ROUND_ROBIN_EN is defined, otherwise fixed priority
// (lowest index wins, no pointer register).
module tl_arb_rr #(
  parameter int NumHosts = 2,
  localparam int IdxW    = $clog2(NumHosts)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumHosts-1:0] req_i,
  input  logic                update_i,
  input  logic [IdxW-1:0]     last_idx_i,
  output logic [NumHosts-1:0] gnt_o,
  output logic [IdxW-1:0]     idx_o
);

`ifdef TL_ARB_ROUND_ROBIN_EN
  logic [IdxW-1:0] ptr_q;

  // Pointer names the host with highest priority: the one after the last completed grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (update_i) begin
      ptr_q <= (last_idx_i == IdxW'(NumHosts - 1)) ? '0 : last_idx_i + 1'b1;
    end
  end
`else
  logic [IdxW-1:0] ptr_q;
  logic            unused_fixed;

  assign ptr_q        = '0;
  assign unused_fixed = ^{clk_i, rst_ni, update_i, last_idx_i};
`endif

  // Scan from the farthest candidate back to the pointer so the nearest requester wins.
  always_comb begin
    int cand;
    cand  = 0;
    gnt_o = '0;
    idx_o = '0;
    for (int off = NumHosts - 1; off >= 0; off--) begin
      cand = (int'(ptr_q) + off) % NumHosts;
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/tl_host_arbiter.sv
// N-to-1 TL-UH host arbiter with burst locking and source-tagged response routing.
// Define TL_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module tl_host_arbiter
  import tl_pkg::*;
#(
  parameter int NumHosts    = 2,
  parameter int SourceWidth = 1,
  parameter int SinkWidth   = 1,
  parameter int AddrWidth   = 56,
  parameter int DataWidth   = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  tl_host_arbiter_if.slave   tl
);

  localparam int          IdxW          = $clog2(NumHosts);
  localparam int unsigned BeatBytesLog2 = $clog2(DataWidth / 8);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [0:0]          state_q;
  logic [IdxW-1:0]     lock_idx_q;
  logic [TlCntW-1:0]   beat_cnt_q;
  logic [NumHosts-1:0] pick_gnt;
  logic [IdxW-1:0]     pick_idx;
  logic [IdxW-1:0]     grant_idx;
  logic                grant_any;
  logic [TlCntW-1:0]   first_beats;
  logic                accept;
  logic                last_beat;
  logic [IdxW-1:0]     d_idx;
  logic                unused_widths;

  // Field widths are fixed by the interface; these parameters only document the instance.
  assign unused_widths = ^{AddrWidth, SinkWidth};

  tl_arb_rr #(.NumHosts(NumHosts)) u_arb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (tl.host_a_valid),
    .update_i   (last_beat),
    .last_idx_i (grant_idx),
    .gnt_o      (pick_gnt),
    .idx_o      (pick_idx)
  );

  // A path is a pure mux: the locked host keeps the grant even while its valid is low.
  always_comb begin
    grant_idx         = (state_q == StLocked) ? lock_idx_q : pick_idx;
    grant_any         = (state_q == StLocked) || (|pick_gnt);
    tl.device_a_valid = 1'b0;
    tl.device_a       = '0;
    tl.host_a_ready   = '0;
    for (int i = 0; i < NumHosts; i++) begin
      if (grant_any && grant_idx == IdxW'(i)) begin
        tl.device_a_valid     = tl.host_a_valid[i];
        tl.host_a_ready[i]    = tl.device_a_ready;
        tl.device_a.opcode    = tl.host_a[i].opcode;
        tl.device_a.param     = tl.host_a[i].param;
        tl.device_a.size      = tl.host_a[i].size;
        tl.device_a.source    = {IdxW'(i), tl.host_a[i].source};
        tl.device_a.address   = tl.host_a[i].address;
        tl.device_a.mask      = tl.host_a[i].mask;
        tl.device_a.data      = tl.host_a[i].data;
      end
    end
  end

  assign first_beats = tl_beats(tl.device_a.opcode, tl.device_a.size, BeatBytesLog2);
  assign accept      = tl.device_a_valid && tl.device_a_ready;
  assign last_beat   = accept && ((state_q == StIdle) ? (first_beats == TlCntW'(1))
                                                      : (beat_cnt_q == TlCntW'(1)));

  // Counter holds beats still owed after the current one; the lock drops on the beat at count 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      lock_idx_q <= '0;
      beat_cnt_q <= '0;
    end else if (accept) begin
      if (state_q == StIdle) begin
        if (first_beats > TlCntW'(1)) begin
          state_q    <= StLocked;
          lock_idx_q <= grant_idx;
          beat_cnt_q <= first_beats - TlCntW'(1);
        end
      end else begin
        beat_cnt_q <= beat_cnt_q - TlCntW'(1);
        if (beat_cnt_q == TlCntW'(1)) begin
          state_q <= StIdle;
        end
      end
    end
  end

  assign d_idx = tl.device_d.source[SourceWidth +: IdxW];

  // Responses with an index beyond the last host are accepted and dropped.
  always_comb begin
    tl.host_d_valid   = '0;
    tl.device_d_ready = 1'b1;
    for (int i = 0; i < NumHosts; i++) begin
      tl.host_d[i].opcode = tl.device_d.opcode;
      tl.host_d[i].param  = tl.device_d.param;
      tl.host_d[i].size   = tl.device_d.size;
      tl.host_d[i].source = tl.device_d.source[SourceWidth-1:0];
      tl.host_d[i].sink   = tl.device_d.sink;
      tl.host_d[i].data   = tl.device_d.data;
      tl.host_d[i].error  = tl.device_d.error;
      if (d_idx == IdxW'(i)) begin
        tl.host_d_valid[i] = tl.device_d_valid;
        tl.device_d_ready  = tl.host_d_ready[i];
      end
    end
  end

endmodule

// File: tb/tb_tl_host_arbiter.sv
// Directed bench for tl_host_arbiter (2 hosts, 64-bit data, 2-bit host source).
module tb_tl_host_arbiter;
  import tl_pkg::*;

  localparam int NumHosts    = 2;
  localparam int SourceWidth = 2;
  localparam int SinkWidth   = 1;
  localparam int AddrWidth   = 56;
  localparam int DataWidth   = 64;

  logic clk = 1'b0;
  logic rst_n;
  int   check_count = 0;
  int   error_count = 0;
  logic [1:0] exp_grant [4];

  tl_host_arbiter_if #(
    .NumHosts(NumHosts), .SourceWidth(SourceWidth), .SinkWidth(SinkWidth),
    .AddrWidth(AddrWidth), .DataWidth(DataWidth)
  ) tl ();

  tl_host_arbiter #(
    .NumHosts(NumHosts), .SourceWidth(SourceWidth), .SinkWidth(SinkWidth),
    .AddrWidth(AddrWidth), .DataWidth(DataWidth)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .tl     (tl)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int h, input logic valid, input tl_a_op_e op,
                               input logic [3:0] size, input logic [1:0] src, input logic [63:0] data);
    tl.host_a_valid[h]     = valid;
    tl.host_a[h].opcode    = op;
    tl.host_a[h].param     = 3'd0;
    tl.host_a[h].size      = size;
    tl.host_a[h].source    = src;
    tl.host_a[h].address   = 56'(32'h4000 + h * 32'h100);
    tl.host_a[h].mask      = '1;
    tl.host_a[h].data      = data;
  endtask

  initial begin
    rst_n             = 1'b0;
    tl.host_a_valid   = '0;
    tl.host_a[0]      = '0;
    tl.host_a[1]      = '0;
    tl.device_a_ready = 1'b1;
    tl.device_d_valid = 1'b0;
    tl.device_d       = '0;
    tl.host_d_ready   = '0;
`ifdef TL_ARB_ROUND_ROBIN_EN
    exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_grant = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    // Reset state with nothing requesting
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_dev_a_valid", 64'(tl.device_a_valid), 64'd0);
    checkOutput("reset_host_a_ready", 64'(tl.host_a_ready), 64'd0);

    // Both hosts Get together: host 0 first, then host 1
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, Get, 4'd3, 2'b01, 64'hA0);
    applyStimulus(1, 1'b1, Get, 4'd3, 2'b10, 64'hB1);
    #1;
    checkOutput("get_dev_valid", 64'(tl.device_a_valid), 64'd1);
    checkOutput("get_first_ready", 64'(tl.host_a_ready), 64'b01);
    checkOutput("get_first_source", 64'(tl.device_a.source), 64'b001);
    checkOutput("get_first_addr", 64'(tl.device_a.address), 64'h4000);
    @(negedge clk);
    tl.host_a_valid[0] = 1'b0;
    #1;
    checkOutput("get_second_ready", 64'(tl.host_a_ready), 64'b10);
    checkOutput("get_second_source", 64'(tl.device_a.source), 64'b110);
    checkOutput("get_second_addr", 64'(tl.device_a.address), 64'h4100);
    @(negedge clk);
    tl.host_a_valid[1] = 1'b0;

    // Four-beat Put from host 1 with a two-cycle valid gap; host 0 waits throughout
    @(negedge clk);
    applyStimulus(1, 1'b1, PutFullData, 4'd5, 2'b11, 64'hD0);
    #1;
    checkOutput("put_beat1_ready", 64'(tl.host_a_ready), 64'b10);
    checkOutput("put_beat1_source", 64'(tl.device_a.source), 64'b111);
    @(negedge clk);
    applyStimulus(0, 1'b1, Get, 4'd3, 2'b01, 64'hA2);
    tl.host_a[1].data = 64'hD1;
    #1;
    checkOutput("put_beat2_ready", 64'(tl.host_a_ready), 64'b10);
    checkOutput("put_beat2_data", tl.device_a.data, 64'hD1);
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      tl.host_a_valid[1] = 1'b0;
      #1;
      checkOutput($sformatf("put_gap%0d_dev_valid", g), 64'(tl.device_a_valid), 64'd0);
      checkOutput($sformatf("put_gap%0d_ready", g), 64'(tl.host_a_ready), 64'b10);
    end
    @(negedge clk);
    tl.host_a_valid[1] = 1'b1;
    tl.host_a[1].data  = 64'hD2;
    #1;
    checkOutput("put_beat3_ready", 64'(tl.host_a_ready), 64'b10);
    checkOutput("put_beat3_data", tl.device_a.data, 64'hD2);
    @(negedge clk);
    tl.host_a[1].data = 64'hD3;
    #1;
    checkOutput("put_beat4_ready", 64'(tl.host_a_ready), 64'b10);
    checkOutput("put_beat4_source", 64'(tl.device_a.source), 64'b111);
    @(negedge clk);
    tl.host_a_valid[1] = 1'b0;
    #1;
    checkOutput("after_put_ready", 64'(tl.host_a_ready), 64'b01);
    checkOutput("after_put_source", 64'(tl.device_a.source), 64'b001);
    @(negedge clk);
    tl.host_a_valid[0] = 1'b0;

    // Response routing by the upper source bit, including backpressure
    tl.device_d_valid  = 1'b1;
    tl.device_d.opcode = AccessAckData;
    tl.device_d.source = 3'b110;
    tl.device_d.data   = 64'hDD;
    tl.host_d_ready    = 2'b10;
    #1;
    checkOutput("d_host1_valid", 64'(tl.host_d_valid), 64'b10);
    checkOutput("d_host1_source", 64'(tl.host_d[1].source), 64'b10);
    checkOutput("d_host1_data", tl.host_d[1].data, 64'hDD);
    checkOutput("d_host1_ready", 64'(tl.device_d_ready), 64'd1);
    tl.host_d_ready = 2'b01;
    #1;
    checkOutput("d_host1_stall", 64'(tl.device_d_ready), 64'd0);
    tl.device_d.source = 3'b001;
    #1;
    checkOutput("d_host0_valid", 64'(tl.host_d_valid), 64'b01);
    checkOutput("d_host0_source", 64'(tl.host_d[0].source), 64'b01);
    checkOutput("d_host0_ready", 64'(tl.device_d_ready), 64'd1);
    tl.device_d_valid = 1'b0;

    // Host 0 always valid: fixed priority starves host 1, round-robin alternates
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, Get, 4'd3, 2'b00, 64'hA3);
    applyStimulus(1, 1'b1, Get, 4'd3, 2'b01, 64'hB3);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checkOutput($sformatf("prio_grant%0d", k), 64'(tl.host_a_ready), 64'(exp_grant[k]));
    end
    @(negedge clk);
    tl.host_a_valid = '0;

    // Reset after beat 2 of a four-beat Put abandons the lock
    @(negedge clk);
    applyStimulus(1, 1'b1, PutFullData, 4'd5, 2'b10, 64'hE0);
    @(negedge clk);
    tl.host_a[1].data = 64'hE1;
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(0, 1'b1, Get, 4'd3, 2'b01, 64'hA4);
    #1;
    checkOutput("rst_mid_ready", 64'(tl.host_a_ready), 64'b01);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_release_ready", 64'(tl.host_a_ready), 64'b01);
    checkOutput("rst_release_source", 64'(tl.device_a.source), 64'b001);
    checkOutput("rst_release_opcode", 64'(tl.device_a.opcode), 64'(Get));
    @(negedge clk);
    tl.host_a_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/tl_host_arbiter.md
TL_HOST_ARBITER -- requirements
Module: tl_host_arbiter

Interface
REQ-001 Parameter NumHosts, default 2: number of upstream TL-UH hosts sharing one device port (2..8).
REQ-002 Parameter SourceWidth, default 1: host-side source width; device-side source width SHALL be SourceWidth+$clog2(NumHosts).
REQ-003 Parameter SinkWidth, default 1: sink field width, passed through unchanged.
REQ-004 Parameter AddrWidth, default 56: address width.
REQ-005 Parameter DataWidth, default 64: data width in bits; beat bytes = DataWidth/8.
REQ-006 Port clk_i, input, 1: clock, rising edge.
REQ-007 Port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-008 Ports host_a_valid / host_a_ready / host_a: input / output / input, NumHosts x (1 / 1 / A struct): per-host request channel.
REQ-009 Ports host_d_valid / host_d_ready / host_d: output / input / output, NumHosts x (1 / 1 / D struct): per-host grant channel.
REQ-010 Ports device_a_valid / device_a_ready / device_a: output / input / output, 1 / 1 / A struct (wide source): shared request channel.
REQ-011 Ports device_d_valid / device_d_ready / device_d: input / output / input, 1 / 1 / D struct (wide source): shared grant channel.

Function
REQ-012 A path SHALL be zero-latency, with no storage: device_a_valid = granted host's valid; host_a_ready[i] = device_a_ready && grant==i; all other readies 0.
REQ-013 device_a.source SHALL be {host index, host source}; all other A fields SHALL pass through unchanged.
REQ-014 State machine: IDLE (no lock) and LOCKED (grant held). In IDLE, grant SHALL be chosen combinationally among asserted valids per the REQ-021 policy.
REQ-015 Beats per A message: PutFullData/PutPartialData with 2^size > beat bytes SHALL have 2^size/(DataWidth/8) beats; every other opcode SHALL have 1 beat.
REQ-016 An accepted first beat of a multi-beat message SHALL load the beat counter with beats-1 and enter LOCKED on the held index; each accepted beat in LOCKED SHALL decrement the counter; acceptance at counter 1 SHALL return to IDLE.
REQ-017 In LOCKED, grant SHALL stay on the locked host even when its valid is low; other hosts SHALL NOT be granted.
REQ-018 The arbitration pointer SHALL update only on acceptance of a message's last beat (single-beat counts as last).
REQ-019 D path SHALL be zero-latency: index = upper $clog2(NumHosts) bits of device_d.source; host_d_valid[index] = device_d_valid; device_d_ready = host_d_ready[index]; host_d.source = lower SourceWidth bits.
REQ-020 An out-of-range D index (NumHosts not a power of 2) SHALL drive no host valid and device_d_ready=1, dropping the beat.

Configuration
REQ-021 Macro TL_ARB_ROUND_ROBIN_EN: when defined, priority SHALL be round-robin starting at the index after the last host granted a completed message; when undefined, fixed priority SHALL apply (lowest index wins) and the pointer register SHALL be absent.

Reset
REQ-022 On rst_ni low: state IDLE, beat counter 0, round-robin pointer 0 (next priority is host 0).
REQ-023 Reset mid-burst SHALL abandon the lock immediately; outputs SHALL follow only the combinational rules with IDLE state.

Structure
REQ-024 A/D struct typedefs and the opcode encodings SHALL come from tl_pkg; the beats-from-size function SHALL be added to tl_pkg for reuse.
REQ-025 One sub-module, tl_arb_rr (NumHosts-wide round-robin/fixed-priority picker with one-hot grant and index outputs), is natural.

Verification
REQ-026 Bench parameters: NumHosts=2, DataWidth=64, SourceWidth=2.
REQ-027 Both hosts Get (size 3) in the same cycle after reset -> host 0 granted first, device source 3'b0xx; host 1 granted the next cycle with source 3'b1xx (round-robin build).
REQ-028 Host 1 PutFullData size 5 (4 beats) with host 0 valid throughout -> four host-1 beats contiguous, including when host 1 deasserts valid for 2 cycles mid-burst; host 0 granted only after the 4th beat.
REQ-029 device_d source 3'b110 -> host_d_valid[1]=1, host_d[1].source=2'b10; host_d_ready[1]=0 stalls device_d_ready=0.
REQ-030 Host 0 continuously valid with fixed priority (macro undefined) -> host 1 never granted; with the macro defined -> grants alternate 0,1,0,1.
REQ-031 rst_ni asserted after beat 2 of a 4-beat Put -> after release, state IDLE and host 0 granted when both hosts are valid.
